// File: rtl/bcp_pkg.sv
// bcp_pkg: shared FSM type, default sizes and literal-mask helpers for the BCP path
package bcp_pkg;
  localparam int VAR_NUM_DEF = 8;
  localparam int CLAUSE_NUM_DEF = 8;
  localparam int MAX_VAR = 32;
  localparam int MASK_W = 2 * MAX_VAR;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic logic [MAX_VAR-1:0] pos_half(input logic [MASK_W-1:0] mask, input int n);
    return MAX_VAR'(mask & ~({MASK_W{1'b1}} << n));
  endfunction
  function automatic logic [MAX_VAR-1:0] neg_half(input logic [MASK_W-1:0] mask, input int n);
    return MAX_VAR'(mask >> n);
  endfunction
endpackage

// File: rtl/bcp_clause_eval.sv
// bcp_clause_eval: combinational evaluation of one clause against a partial assignment
module bcp_clause_eval import bcp_pkg::*; #(
  parameter int VAR_NUM = VAR_NUM_DEF
) (
  input  logic [2*VAR_NUM-1:0]       clause,
  input  logic [VAR_NUM-1:0]         assignment,
  input  logic [VAR_NUM-1:0]         free,
  output logic                       satisfied,
  output logic                       unit,
  output logic                       conflict,
  output logic [$clog2(VAR_NUM)-1:0] unit_var,
  output logic                       unit_val
);
  localparam int CW = $clog2(2 * VAR_NUM + 1);
  localparam int IW = $clog2(VAR_NUM);
  logic [VAR_NUM-1:0] pos, neg, pos_free, neg_free;
  logic [CW-1:0] cnt;
  assign pos = VAR_NUM'(pos_half(MASK_W'(clause), VAR_NUM));
  assign neg = VAR_NUM'(neg_half(MASK_W'(clause), VAR_NUM));
  assign pos_free = pos & free;
  assign neg_free = neg & free;
  assign satisfied = |(pos & assignment & ~free) | |(neg & ~assignment & ~free);
  // a tautology on a free variable counts twice, so it never looks like a unit
  always_comb begin
    cnt = '0;
    unit_var = '0;
    unit_val = 1'b0;
    for (int i = 0; i < VAR_NUM; i++) begin
      if (pos_free[i]) begin
        cnt = cnt + CW'(1);
        unit_var = IW'(i);
        unit_val = 1'b1;
      end
      if (neg_free[i]) begin
        cnt = cnt + CW'(1);
        unit_var = IW'(i);
        unit_val = 1'b0;
      end
    end
  end
  assign unit = cnt == CW'(1);
  assign conflict = |clause && !satisfied && cnt == '0;
endmodule

// File: rtl/bcp_controller.sv
// bcp_controller: clause table plus pass-repeating BCP sequencer up to fixpoint or conflict
module bcp_controller import bcp_pkg::*; #(
  parameter int VAR_NUM    = VAR_NUM_DEF,
  parameter int CLAUSE_NUM = CLAUSE_NUM_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clause_wr_en,
  input  logic [$clog2(CLAUSE_NUM)-1:0] clause_wr_addr,
  input  logic [2*VAR_NUM-1:0]          clause_wr_data,
  input  logic                          start,
  input  logic [VAR_NUM-1:0]            assignment_in,
  input  logic [VAR_NUM-1:0]            free_in,
  output logic                          busy,
  output logic                          done,
  output logic                          conflict,
  output logic [$clog2(CLAUSE_NUM)-1:0] conflict_clause,
  output logic [VAR_NUM-1:0]            assignment_out,
  output logic [VAR_NUM-1:0]            free_out,
  output logic [$clog2(VAR_NUM+1)-1:0]  implication_count
);
  localparam int AW = $clog2(CLAUSE_NUM);
  localparam int CW = $clog2(VAR_NUM + 1);
  state_t state, state_next;
  logic [2*VAR_NUM-1:0] clause_mem [CLAUSE_NUM];
  logic [AW-1:0] k;
  logic changed, last, implied;
  logic ev_sat, ev_unit, ev_conflict, ev_val;
  logic [$clog2(VAR_NUM)-1:0] ev_var;
  bcp_clause_eval #(.VAR_NUM(VAR_NUM)) u_eval (
    .clause(clause_mem[k]),
    .assignment(assignment_out),
    .free(free_out),
    .satisfied(ev_sat),
    .unit(ev_unit),
    .conflict(ev_conflict),
    .unit_var(ev_var),
    .unit_val(ev_val)
  );
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign last = k == AW'(CLAUSE_NUM - 1);
  assign implied = ev_unit && !ev_sat;
  // an implication on the last clause still forces another pass
  always_comb begin
    state_next = state == IDLE ? (start ? SCAN : IDLE)
               : state == SCAN ? ((ev_conflict || (last && !changed && !implied)) ? DONE : SCAN)
               : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      changed <= 1'b0;
      conflict <= 1'b0;
      conflict_clause <= '0;
      implication_count <= '0;
      assignment_out <= '0;
      free_out <= '1;
      for (int i = 0; i < CLAUSE_NUM; i++) clause_mem[i] <= '0;
    end else begin
      state <= state_next;
      if (clause_wr_en && state == IDLE) clause_mem[clause_wr_addr] <= clause_wr_data;
      if (state == IDLE && start) begin
        assignment_out <= assignment_in;
        free_out <= free_in;
        implication_count <= '0;
        k <= '0;
        changed <= 1'b0;
        conflict <= 1'b0;
        conflict_clause <= '0;
      end
      if (state == SCAN) begin
        if (ev_conflict) begin
          conflict <= 1'b1;
          conflict_clause <= k;
        end else begin
          if (implied) begin
            assignment_out[ev_var] <= ev_val;
            free_out[ev_var] <= 1'b0;
            implication_count <= implication_count + CW'(1);
          end
          k <= last ? '0 : k + AW'(1);
          changed <= !last && (changed || implied);
        end
      end
    end
  end
endmodule

// File: tb/tb_bcp_controller.sv
// tb_bcp_controller: directed test-plan steps plus random tables checked against a pass-level model
module tb_bcp_controller;
  logic clock, reset, clause_wr_en, start;
  logic [2:0] clause_wr_addr;
  logic [15:0] clause_wr_data;
  logic [7:0] assignment_in, free_in, assignment_out, free_out;
  logic busy, done, conflict;
  logic [2:0] conflict_clause;
  logic [3:0] implication_count;
  logic [15:0] tbl [8];
  int n_cmp, n_err;
  int r_lat;
  bit r_seen;
  logic [7:0] r_asg, r_free;
  logic r_conf;
  logic [2:0] r_cc;
  logic [3:0] r_cnt;

  bcp_controller dut (
    .clock(clock), .reset(reset), .clause_wr_en(clause_wr_en), .clause_wr_addr(clause_wr_addr),
    .clause_wr_data(clause_wr_data), .start(start), .assignment_in(assignment_in), .free_in(free_in),
    .busy(busy), .done(done), .conflict(conflict), .conflict_clause(conflict_clause),
    .assignment_out(assignment_out), .free_out(free_out), .implication_count(implication_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    clause_wr_en = 1'b1;
    clause_wr_addr = a;
    clause_wr_data = d;
    @(posedge clock);
    #1 clause_wr_en = 1'b0;
    tbl[a] = d;
  endtask

  // mode 1: extra start and table write at t+4; mode 2: additionally reset at t+5
  task automatic run(input string tag, input int mode, input logic [7:0] a_in, input logic [7:0] f_in);
    assignment_in = a_in;
    free_in = f_in;
    start = 1'b1;
    r_seen = 0;
    @(posedge clock);
    #1 start = 1'b0;
    chk({tag, ".busy_t1"}, busy, 1);
    r_lat = 1;
    while (r_lat < 200 && !r_seen) begin
      if (done) r_seen = 1;
      else begin
        if (mode > 0 && r_lat == 4) begin
          start = 1'b1;
          assignment_in = ~a_in;
          free_in = 8'h00;
          clause_wr_en = 1'b1;
          clause_wr_addr = 3'd2;
          clause_wr_data = 16'h0100;
        end
        if (mode == 2 && r_lat == 5) reset = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        clause_wr_en = 1'b0;
        if (reset) begin
          reset = 1'b0;
          for (int i = 0; i < 8; i++) tbl[i] = '0;
          chk({tag, ".rst_busy"}, busy, 0);
          chk({tag, ".rst_free"}, free_out, 8'hFF);
          chk({tag, ".rst_done"}, done, 0);
          for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            if (done) r_seen = 1;
          end
          chk({tag, ".no_done_after_rst"}, r_seen, 0);
          return;
        end
        r_lat++;
      end
    end
    if (r_seen) begin
      r_asg = assignment_out;
      r_free = free_out;
      r_conf = conflict;
      r_cc = conflict_clause;
      r_cnt = implication_count;
      chk({tag, ".busy_at_done"}, busy, 1);
      @(posedge clock);
      #1;
      chk({tag, ".done_pulse"}, done, 0);
      chk({tag, ".busy_after"}, busy, 0);
    end else chk({tag, ".done_timeout"}, r_seen, 1);
  endtask

  task automatic want(input string tag, input int lat, input bit conf, input int cc,
                      input logic [7:0] asg, input logic [7:0] fr, input int cnt);
    chk({tag, ".latency"}, r_lat, lat);
    chk({tag, ".conflict"}, r_conf, conf);
    if (conf) chk({tag, ".conflict_clause"}, r_cc, cc);
    chk({tag, ".assignment"}, r_asg, asg);
    chk({tag, ".free"}, r_free, fr);
    chk({tag, ".count"}, r_cnt, cnt);
  endtask

  // whole passes over the clause list with immediate application of unit implications
  task automatic model(input logic [7:0] a_in, input logic [7:0] f_in, output int lat, output bit conf,
                       output int cc, output logic [7:0] asg, output logic [7:0] fr, output int cnt);
    bit ch, sat, uval, pol;
    int nfree, uv, v;
    asg = a_in;
    fr = f_in;
    cnt = 0;
    conf = 0;
    cc = 0;
    lat = 0;
    for (int p = 0; p <= 9 && lat == 0; p++) begin
      ch = 0;
      for (int c = 0; c < 8 && lat == 0; c++) begin
        if (tbl[c] == 16'h0) continue;
        nfree = 0;
        uv = 0;
        sat = 0;
        uval = 0;
        for (int lit = 0; lit < 16; lit++) begin
          v = lit % 8;
          pol = lit < 8;
          if (tbl[c][lit]) begin
            if (fr[v]) begin
              nfree++;
              uv = v;
              uval = pol;
            end else if (asg[v] == pol) sat = 1;
          end
        end
        if (sat) continue;
        if (nfree == 0) begin
          conf = 1;
          cc = c;
          lat = 2 + p * 8 + c;
        end else if (nfree == 1) begin
          asg[uv] = uval;
          fr[uv] = 1'b0;
          cnt++;
          ch = 1;
        end
      end
      if (lat == 0 && !ch) lat = 1 + (p + 1) * 8;
    end
  endtask

  initial begin
    int m_lat, m_cc, m_cnt, n;
    bit m_conf;
    logic [7:0] m_asg, m_fr, a, f;
    logic [15:0] d;
    string tag;
    n_cmp = 0;
    n_err = 0;
    start = 0;
    clause_wr_en = 0;
    clause_wr_addr = 0;
    clause_wr_data = 0;
    assignment_in = 0;
    free_in = 8'hFF;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.conflict", conflict, 0);
    chk("reset.conflict_clause", conflict_clause, 0);
    chk("reset.count", implication_count, 0);
    chk("reset.assignment", assignment_out, 0);
    chk("reset.free", free_out, 8'hFF);

    wr(0, 16'h0001);
    run("s1", 0, 8'h00, 8'hFF);
    want("s1", 17, 0, 0, 8'h01, 8'hFE, 1);

    do_reset();
    wr(0, 16'h0001);
    wr(1, 16'h0102);
    run("s2a", 0, 8'h00, 8'hFF);
    want("s2a", 17, 0, 0, 8'h03, 8'hFC, 2);
    do_reset();
    wr(0, 16'h0102);
    wr(1, 16'h0001);
    run("s2b", 0, 8'h00, 8'hFF);
    want("s2b", 25, 0, 0, 8'h03, 8'hFC, 2);

    do_reset();
    wr(0, 16'h0001);
    wr(1, 16'h0100);
    run("s3", 0, 8'h00, 8'hFF);
    want("s3", 3, 1, 1, 8'h01, 8'hFE, 1);

    do_reset();
    wr(0, 16'h0080);
    run("s4", 0, 8'h80, 8'h7F);
    want("s4", 9, 0, 0, 8'h80, 8'h7F, 0);

    do_reset();
    wr(0, 16'h0001);
    wr(1, 16'h0102);
    run("s5a", 1, 8'h00, 8'hFF);
    want("s5a", 17, 0, 0, 8'h03, 8'hFC, 2);
    run("s5b", 2, 8'h00, 8'hFF);
    run("s5c", 0, 8'h00, 8'hFF);
    want("s5c", 9, 0, 0, 8'h00, 8'hFF, 0);

    do_reset();
    run("s6a", 0, 8'h00, 8'hFF);
    want("s6a", 9, 0, 0, 8'h00, 8'hFF, 0);
    wr(0, 16'h0001);
    wr(0, 16'h0000);
    run("s6b", 0, 8'h00, 8'hFF);
    want("s6b", 9, 0, 0, 8'h00, 8'hFF, 0);

    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 8; c++) begin
        d = '0;
        if ($urandom_range(0, 9) < 6) begin
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) d[$urandom_range(0, 15)] = 1'b1;
        end
        wr(3'(c), d);
      end
      a = 8'($urandom);
      f = 8'($urandom) | 8'($urandom);
      tag = $sformatf("rnd%0d", t);
      model(a, f, m_lat, m_conf, m_cc, m_asg, m_fr, m_cnt);
      run(tag, 0, a, f);
      want(tag, m_lat, m_conf, m_cc, m_asg, m_fr, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcp_controller.md
# bcp_controller

Sequencer for the hardware BCP (Boolean constraint propagation) path of the SAT engine. Holds a small clause table and scans it one clause per cycle against the current partial assignment. Applies every unit implication immediately and repeats full passes until a fixpoint or a conflict is reached. Sits between the search controller, which issues decisions and `start`, and the per-clause evaluator.

## Interface
Parameters:
- `VAR_NUM`, 8, number of variables.
- `CLAUSE_NUM`, 8, clause table depth.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clause_wr_en`  in  1  write the clause table entry.
- `clause_wr_addr`  in  $clog2(CLAUSE_NUM)  entry index.
- `clause_wr_data`  in  2*VAR_NUM  literal mask: bit i = positive literal of var i; bit VAR_NUM+i = negative literal of var i.
- `start`  in  1  begin propagation; inputs are captured this cycle.
- `assignment_in`  in  VAR_NUM  variable values.
- `free_in`  in  VAR_NUM  1 = variable unassigned.
- `busy`  out  1  propagation in progress.
- `done`  out  1  one-cycle completion pulse.
- `conflict`  out  1  result flag, valid while `done`.
- `conflict_clause`  out  $clog2(CLAUSE_NUM)  index of the falsified clause.
- `assignment_out`  out  VAR_NUM  resulting values.
- `free_out`  out  VAR_NUM  resulting free mask.
- `implication_count`  out  $clog2(VAR_NUM+1)  variables implied in this run.

## Operation
- **Clause table**
  - Non-zero write data makes the entry valid. All-zero data invalidates it.
  - Writes are ignored while `busy`.
  - Invalid entries still occupy their scan cycle and have no effect.
- **FSM states:** IDLE, SCAN, DONE.
  - IDLE: `start` captures `assignment_in`/`free_in`, clears the count, clause index and `changed` flag, then goes to SCAN.
  - SCAN: evaluates the entry at index k against the working assignment.
    - Satisfied: any literal whose variable is assigned with matching polarity.
    - Unassigned literal count: set bits whose variable is free. A tautology on a free variable counts 2.
    - Not satisfied, count 0 → conflict. Latch `conflict_clause`=k and go to DONE.
    - Not satisfied, count 1 → implication. Write the variable value (1 for positive literal, 0 for negative), clear its free bit, increment the count, set `changed`. The update is visible to clause k+1 in the next cycle.
    - k = CLAUSE_NUM-1 without conflict: if `changed`, clear it, set k=0 and stay in SCAN. Otherwise go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- **Outputs**
  - `conflict` and `conflict_clause` hold until the next `start`.
  - `assignment_out`/`free_out` mirror the working registers continuously.
- **Boundary cases**
  - `start` while busy is ignored.
  - The pass count is bounded by VAR_NUM+1; no extra limit logic.
  - Empty table: one pass, no change.
  - Reset mid-scan aborts the run and returns to IDLE.

## Timing
- `start` at cycle t → clause 0 of pass 0 is evaluated at t+1.
- Clause k of pass p is evaluated at t+1+p·CLAUSE_NUM+k.
- Fixpoint after P passes → `done` at t+1+P·CLAUSE_NUM.
- Conflict on clause k of pass p → `done` at t+2+p·CLAUSE_NUM+k.
- `busy` is high from t+1 through the `done` cycle inclusive.
- Reset values:
  - state IDLE;
  - `busy`, `done`, `conflict` = 0;
  - `conflict_clause`, `implication_count`, `assignment_out` = 0;
  - `free_out` all ones;
  - all clause entries invalid.

## Structure
- Shared package `bcp_pkg`:
  - FSM state enum;
  - default VAR_NUM/CLAUSE_NUM;
  - literal-mask helper functions (positive/negative half select).
- Sub-module `bcp_clause_eval`, combinational:
  - inputs: clause, assignment, free;
  - outputs: satisfied, unit, conflict, unit_var, unit_val.
- Controller holds the FSM, clause table, working registers and counters.

## Test plan
All scenarios use defaults; all clauses are invalid unless listed; `free_in`=8'hFF and `assignment_in`=8'h00 unless listed.
1. Clause0=16'h0001, start → `done` at t+17, `assignment_out`=8'h01, `free_out`=8'hFE, count=1, `conflict`=0.
2. Chain, in order: c0=16'h0001, c1=16'h0102 → `done` at t+17, `assignment_out`=8'h03, `free_out`=8'hFC, count=2. Reversed (c0=16'h0102, c1=16'h0001) → `done` at t+25, same result.
3. Conflict: c0=16'h0001, c1=16'h0100 → `done` at t+3, `conflict`=1, `conflict_clause`=1, count=1, `free_out`=8'hFE.
4. Pre-satisfied: `assignment_in`=8'h80, `free_in`=8'h7F, c0=16'h0080 → `done` at t+9, outputs equal inputs, count=0.
5. Second `start` at t+4 of scenario 2 is ignored, and a `clause_wr_en` at t+4 does not alter the table. Reset at t+5 → `busy`=0, `free_out`=8'hFF, no `done`, all entries invalid.
6. Empty table, start → `done` at t+9, `conflict`=0, count=0; then write all-zero data to a valid entry and rerun → same as empty.
